// File: rtl/rob_pkg.sv
// Shared defaults and entry bookkeeping type for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_DEPTH    = 16;
    localparam int unsigned ROB_XLEN     = 32;
    localparam int unsigned ROB_WB_PORTS = 2;
    localparam int unsigned TAG_NONE     = 0;

    // Wide payload (rd, pc, data, target) lives in per-field arrays so XLEN stays a module parameter.
    typedef struct packed {
        logic busy;
        logic ready;
        logic is_branch;
        logic is_store;
        logic pred_taken;
        logic taken;
    } rob_entry_t;

endpackage

// File: rtl/rob_wb_match.sv
// Maps writeback ports onto ROB entries; a busy entry takes the lowest-numbered matching port.
module rob_wb_match
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = ROB_DEPTH,
    parameter int unsigned WB_PORTS = ROB_WB_PORTS,
    parameter int unsigned TAG_W    = $clog2(DEPTH) + 1,
    parameter int unsigned PSEL_W   = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1
) (
    input  logic [WB_PORTS-1:0]       wb_valid_in,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag_in,
    input  logic [DEPTH-1:0]          busy_in,
    output logic [DEPTH-1:0]          hit_out,
    output logic [PSEL_W-1:0]         sel_out [DEPTH]
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;

    always_comb begin
        hit_out = '0;
        tag     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_out[i] = '0;
        end
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            tag = wb_tag_in[p*TAG_W +: TAG_W];
            idx = IDX_W'(tag - 1'b1);
            if (wb_valid_in[p] && (tag != TAG_W'(TAG_NONE)) && (tag <= TAG_W'(DEPTH))
                && busy_in[idx] && !hit_out[idx]) begin
                hit_out[idx] = 1'b1;
                sel_out[idx] = PSEL_W'(p);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with out-of-order writeback, operand forwarding
// and branch-mispredict rollback.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH    = ROB_DEPTH,
    parameter int unsigned XLEN     = ROB_XLEN,
    parameter int unsigned WB_PORTS = ROB_WB_PORTS,
    parameter int unsigned TAG_W    = $clog2(DEPTH) + 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       issue_valid_in,
    input  logic [4:0]                 issue_rd_in,
    input  logic                       issue_is_branch_in,
    input  logic                       issue_is_store_in,
    input  logic                       issue_pred_taken_in,
    input  logic [XLEN-1:0]            issue_pc_in,
    input  logic [XLEN-1:0]            issue_fallback_pc_in,
    output logic [TAG_W-1:0]           issue_tag_out,
    output logic                       full_out,
    input  logic [TAG_W-1:0]           q1_in,
    input  logic [TAG_W-1:0]           q2_in,
    output logic                       q1_ready_out,
    output logic                       q2_ready_out,
    output logic [XLEN-1:0]            v1_out,
    output logic [XLEN-1:0]            v2_out,
    input  logic [WB_PORTS-1:0]        wb_valid_in,
    input  logic [WB_PORTS-1:0]        wb_taken_in,
    input  logic [WB_PORTS*TAG_W-1:0]  wb_tag_in,
    input  logic [WB_PORTS*XLEN-1:0]   wb_data_in,
    input  logic [WB_PORTS*XLEN-1:0]   wb_target_in,
    output logic                       commit_valid_out,
    output logic                       commit_store_out,
    output logic [4:0]                 commit_rd_out,
    output logic [TAG_W-1:0]           commit_tag_out,
    output logic [XLEN-1:0]            commit_data_out,
    output logic                       bp_update_out,
    output logic                       bp_taken_out,
    output logic [XLEN-1:0]            bp_pc_out,
    output logic                       flush_out,
    output logic [XLEN-1:0]            flush_pc_out
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PSEL_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

    rob_entry_t       ent_q  [DEPTH];
    rob_entry_t       ent_d  [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  pc_d   [DEPTH];
    logic [XLEN-1:0]  fb_q   [DEPTH];
    logic [XLEN-1:0]  fb_d   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];
    logic [XLEN-1:0]  tgt_q  [DEPTH];
    logic [XLEN-1:0]  tgt_d  [DEPTH];

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;

    logic             commit_valid_q, commit_valid_d;
    logic             commit_store_q, commit_store_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
    logic [XLEN-1:0]  commit_data_q, commit_data_d;
    logic             bp_update_q, bp_update_d;
    logic             bp_taken_q, bp_taken_d;
    logic [XLEN-1:0]  bp_pc_q, bp_pc_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

    logic [DEPTH-1:0]  busy_vec;
    logic [DEPTH-1:0]  wb_hit;
    logic [PSEL_W-1:0] wb_sel [DEPTH];
    logic [XLEN-1:0]   wb_data_a [WB_PORTS];
    logic [XLEN-1:0]   wb_tgt_a  [WB_PORTS];

    rob_entry_t head_ent;
    logic       alloc;
    logic       commit;
    logic       mispredict;

    logic [1:0]       q_rdy;
    logic [XLEN-1:0]  q_val [2];
    logic [TAG_W-1:0] q_tag;
    logic [IDX_W-1:0] q_idx;

    assign full_out      = (count_q == TAG_W'(DEPTH));
    assign issue_tag_out = TAG_W'(tail_q) + 1'b1;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_vec[i] = ent_q[i].busy;
        end
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            wb_data_a[p] = wb_data_in[p*XLEN +: XLEN];
            wb_tgt_a[p]  = wb_target_in[p*XLEN +: XLEN];
        end
    end

    // Frozen cycles must not land writebacks, so the valids are gated here once.
    rob_wb_match #(
        .DEPTH    (DEPTH),
        .WB_PORTS (WB_PORTS),
        .TAG_W    (TAG_W),
        .PSEL_W   (PSEL_W)
    ) u_wb_match (
        .wb_valid_in (wb_valid_in & {WB_PORTS{rdy_in}}),
        .wb_tag_in   (wb_tag_in),
        .busy_in     (busy_vec),
        .hit_out     (wb_hit),
        .sel_out     (wb_sel)
    );

    always_comb begin
        q_rdy = '0;
        q_tag = '0;
        q_idx = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            q_val[k] = '0;
            q_tag    = (k == 0) ? q1_in : q2_in;
            q_idx    = IDX_W'(q_tag - 1'b1);
            if ((q_tag != TAG_W'(TAG_NONE)) && (q_tag <= TAG_W'(DEPTH))) begin
                if (ent_q[q_idx].busy && ent_q[q_idx].ready) begin
                    q_rdy[k] = 1'b1;
                    q_val[k] = data_q[q_idx];
                end else if (wb_hit[q_idx]) begin
                    q_rdy[k] = 1'b1;
                    q_val[k] = wb_data_a[wb_sel[q_idx]];
                end
            end
        end
    end

    assign q1_ready_out = q_rdy[0];
    assign q2_ready_out = q_rdy[1];
    assign v1_out       = q_val[0];
    assign v2_out       = q_val[1];

    always_comb begin
        ent_d   = ent_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        fb_d    = fb_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        head_d  = head_q;
        tail_d  = tail_q;

        head_ent   = ent_q[head_q];
        alloc      = issue_valid_in && !full_out && rdy_in;
        commit     = rdy_in && head_ent.busy && (head_ent.ready || head_ent.is_store);
        mispredict = commit && head_ent.is_branch && (head_ent.taken != head_ent.pred_taken);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_hit[i]) begin
                ent_d[i].ready = 1'b1;
                ent_d[i].taken = wb_taken_in[wb_sel[i]];
                data_d[i]      = wb_data_a[wb_sel[i]];
                tgt_d[i]       = wb_tgt_a[wb_sel[i]];
            end
        end

        if (alloc) begin
            ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, is_branch: issue_is_branch_in,
                              is_store: issue_is_store_in, pred_taken: issue_pred_taken_in,
                              taken: 1'b0};
            rd_d[tail_q]  = issue_rd_in;
            pc_d[tail_q]  = issue_pc_in;
            fb_d[tail_q]  = issue_fallback_pc_in;
            tail_d        = tail_q + 1'b1;
        end

        if (commit) begin
            ent_d[head_q].busy  = 1'b0;
            ent_d[head_q].ready = 1'b0;
            head_d              = head_q + 1'b1;
        end

        count_d = count_q + TAG_W'(alloc) - TAG_W'(commit);

        commit_valid_d = commit;
        commit_store_d = commit && head_ent.is_store;
        commit_rd_d    = commit ? rd_q[head_q] : '0;
        commit_tag_d   = commit ? (TAG_W'(head_q) + 1'b1) : '0;
        commit_data_d  = commit ? data_q[head_q] : '0;
        bp_update_d    = commit && head_ent.is_branch;
        bp_taken_d     = commit && head_ent.is_branch && head_ent.taken;
        bp_pc_d        = (commit && head_ent.is_branch) ? pc_q[head_q] : '0;
        flush_d        = mispredict;
        flush_pc_d     = mispredict ? (head_ent.taken ? tgt_q[head_q] : fb_q[head_q]) : '0;

        // Rollback overrides every update above, including this cycle's issue and writebacks.
        if (mispredict) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_store_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_tag_q   <= '0;
            commit_data_q  <= '0;
            bp_update_q    <= 1'b0;
            bp_taken_q     <= 1'b0;
            bp_pc_q        <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_store_q <= commit_store_d;
            commit_rd_q    <= commit_rd_d;
            commit_tag_q   <= commit_tag_d;
            commit_data_q  <= commit_data_d;
            bp_update_q    <= bp_update_d;
            bp_taken_q     <= bp_taken_d;
            bp_pc_q        <= bp_pc_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Payload is only ever read behind a busy/ready flag, so it needs no reset.
    always_ff @(posedge clk_in) begin
        rd_q   <= rd_d;
        pc_q   <= pc_d;
        fb_q   <= fb_d;
        data_q <= data_d;
        tgt_q  <= tgt_d;
    end

    assign commit_valid_out = commit_valid_q;
    assign commit_store_out = commit_store_q;
    assign commit_rd_out    = commit_rd_q;
    assign commit_tag_out   = commit_tag_q;
    assign commit_data_out  = commit_data_q;
    assign bp_update_out    = bp_update_q;
    assign bp_taken_out     = bp_taken_q;
    assign bp_pc_out        = bp_pc_q;
    assign flush_out        = flush_q;
    assign flush_pc_out     = flush_pc_q;

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of 2, 4..64).
REQ-002 SHALL have parameter XLEN, default 32, data/PC width.
REQ-003 SHALL have parameter WB_PORTS, default 2, writeback channels (port 0 ALU, port 1 LSU).
REQ-004 SHALL have parameter TAG_W, default $clog2(DEPTH)+1, tag width; tag = entry index + 1; tag 0 = "no tag".
REQ-005 SHALL have these ports (clock and reset first):
 clk_in  in  1  sole clock.
 rst_n_in  in  1  asynchronous, active-low reset.
 rdy_in  in  1  global enable; low = freeze.
 issue_valid_in  in  1  allocate request.
 issue_rd_in  in  5  destination register.
 issue_is_branch_in / issue_is_store_in / issue_pred_taken_in  in  1 each  entry kind and prediction.
 issue_pc_in / issue_fallback_pc_in  in  XLEN each  instruction PC; not-taken next PC.
 issue_tag_out  out  TAG_W  tag the next allocation receives.
 full_out  out  1  no free entry.
 q1_in / q2_in  in  TAG_W each  operand tags.
 q1_ready_out / q2_ready_out  out  1 each  operand value available.
 v1_out / v2_out  out  XLEN each  operand values.
 wb_valid_in / wb_taken_in  in  WB_PORTS each  per-port valid; actual branch outcome.
 wb_tag_in  in  WB_PORTS*TAG_W  per-port tag.
 wb_data_in / wb_target_in  in  WB_PORTS*XLEN each  result; taken target.
 commit_valid_out  out  1  one-cycle commit pulse.
 commit_store_out  out  1  store-commit pulse to LSB.
 commit_rd_out / commit_tag_out / commit_data_out  out  5 / TAG_W / XLEN  committed entry.
 bp_update_out / bp_taken_out  out  1 each  predictor update pulse; actual outcome.
 bp_pc_out  out  XLEN  branch PC.
 flush_out  out  1  mispredict rollback pulse.
 flush_pc_out  out  XLEN  redirect PC.

Function
REQ-006 SHALL be a circular queue; head/tail wrap DEPTH-1 -> 0; count is TAG_W bits, 0..DEPTH.
REQ-007 full_out SHALL equal (count == DEPTH), combinational; no allocation while full, even if a commit occurs that cycle.
REQ-008 Allocation SHALL occur when issue_valid_in & !full_out & rdy_in: tail entry busy, not ready, fields captured, tail advances; issue_tag_out = tail+1.
REQ-009 Writeback port p SHALL set ready, data, taken, target of entry wb_tag-1 if wb_valid[p], tag != 0, and entry busy; otherwise ignored; on duplicate tags the lowest port wins.
REQ-010 Operand lookup SHALL be combinational: ready=1, value=data if the entry is ready, else ready=1 with the value forwarded from a same-cycle writeback matching the tag, else ready=0, value=0; tag 0 gives ready=0.
REQ-011 Commit SHALL occur at most once per cycle when head is busy and (ready or is_store): entry freed, head advances, commit outputs registered and valid for exactly one cycle.
REQ-012 A store commit SHALL additionally pulse commit_store_out, with commit_tag_out identifying the store.
REQ-013 A branch commit SHALL pulse bp_update_out with bp_pc_out=pc and bp_taken_out=actual taken.
REQ-014 On a mispredict (taken != predicted) at commit, the ROB SHALL pulse flush_out for one cycle, with flush_pc_out = target if taken, else fallback_pc, alongside the commit pulse. In that same edge all entries SHALL be cleared, head=tail=count=0, and same-cycle issue/writeback SHALL be discarded.
REQ-015 On the same cycle, count SHALL update as count + alloc - commit.
REQ-016 When rdy_in is low, all state SHALL hold and all pulse outputs SHALL be 0 next cycle.

Reset
REQ-017 rst_n_in low SHALL asynchronously clear head, tail, count, and all busy/ready flags, and drive every registered output to 0; issue_tag_out then reads 1 and full_out 0.
REQ-018 A reset asserted mid-operation SHALL discard all in-flight entries; no commit or flush pulse SHALL follow reset release.

Structure
REQ-019 Package rob_pkg SHALL hold default DEPTH/XLEN/WB_PORTS, the tag-0 "none" constant, and the entry struct typedef.
REQ-020 No sub-module is required; the writeback match/priority logic MAY be factored into rob_wb_match.

Verification
REQ-021 Reset, then issue 16 ALU ops with no writeback -> full_out=1 after 16th; 17th ignored; issue_tag_out=1 (wrapped).
REQ-022 Issue tags 1,2; write back tag 2 (0x55) before tag 1 (0xAA) -> commits in order: tag1 data 0xAA, then tag2 0x55, consecutive cycles.
REQ-023 Lookup q1=3 while port 1 writes tag 3 = 0x1234 same cycle -> q1_ready_out=1, v1_out=0x1234.
REQ-024 Branch pc=0x100, pred taken, wb taken=0, fallback 0x104 -> commit pulse, bp_taken_out=0, flush_out=1, flush_pc_out=0x104; next cycle count=0, issue_tag_out=1.
REQ-025 Store issued, no writeback -> commit_store_out=1 one cycle after reaching head; younger ALU entry commits after it.
REQ-026 Drop rst_n_in mid-stream with 5 entries -> outputs 0 immediately, no flush pulse after release.
